pipelined_adder: RTL and testbench

- Parametrised, pipelined two's-complement/unsigned adder-subtractor with a Z/V/N/Cout flag set and a valid/ready stream interface on both sides.
- Splits the WIDTH-bit operation into SEG_W-bit segments, one segment per pipeline stage, with a registered carry between segments. This sets throughput at one op per cycle at any WIDTH.
- Sits in the CPU ALU path where a multi-cycle, back-pressurable arithmetic unit is needed.

---
 rtl/alu_pkg.sv | 16 +
 rtl/adder_seg_stage.sv | 43 ++++
 rtl/pipelined_adder.sv | 167 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: status-word flag positions and the segment-width
// legality check used by the segmented adder.
package alu_pkg;

  localparam int FLAG_Z     = 0;
  localparam int FLAG_V     = 1;
  localparam int FLAG_N     = 2;
  localparam int FLAG_C     = 3;
  localparam int FLAG_COUNT = 4;

  // A segment width is usable only if it tiles the operand exactly.
  function automatic bit seg_width_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One registered SEG_W-bit slice of the pipelined adder: sums its operand
// segment with the incoming carry and captures sum, carry, zero and valid.
module adder_seg_stage #(
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             valid_in,
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             cin,
  output logic [SEG_W-1:0] sum_seg,
  output logic             cout,
  output logic             zero,
  output logic             valid_out,
  output logic             c_msb
);

  logic [SEG_W:0] total;
  logic           carry_into_msb;

  assign total = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cin};
  // Carry into the top bit is recovered from the top bit's sum equation.
  assign carry_into_msb = a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ total[SEG_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_seg   <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      valid_out <= 1'b0;
      c_msb     <= 1'b0;
    end else if (en) begin
      sum_seg   <= total[SEG_W-1:0];
      cout      <= total[SEG_W];
      zero      <= (total[SEG_W-1:0] == '0);
      valid_out <= valid_in;
      c_msb     <= carry_into_msb;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Segmented, back-pressurable adder/subtractor: one SEG_W slice per stage,
// operand skew in front of each slice and result alignment behind it.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int STAGES = (SEG_W > 0) ? (WIDTH / SEG_W) : 1;

  if (!seg_width_ok(WIDTH, SEG_W)) begin : g_bad_seg_w
    $error("pipelined_adder: WIDTH must be a positive multiple of SEG_W");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_carry;
  logic [STAGES-1:0] zero_aligned;
  logic [WIDTH-1:0]  s_aligned;
  logic              top_c_msb;
  logic [1:0]        mode_q [STAGES];
  logic [FLAG_COUNT-1:0] flags;
  logic              sign_out;
  logic              sub_out;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = cin ^ sub;

  // sign/sub travel alongside the beat so the flags use the beat's own mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) mode_q[k] <= 2'b00;
    end else if (adv) begin
      mode_q[0] <= {sign, sub};
      for (int k = 1; k < STAGES; k++) mode_q[k] <= mode_q[k-1];
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    localparam int LO    = j * SEG_W;
    localparam int DELAY = STAGES - 1 - j;

    logic [SEG_W-1:0] op_a;
    logic [SEG_W-1:0] op_b;
    logic             seg_cin;
    logic             seg_vin;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_zero;
    logic             seg_c_msb;

    if (j == 0) begin : g_first
      assign op_a    = a[LO +: SEG_W];
      assign op_b    = b_eff[LO +: SEG_W];
      assign seg_cin = c0;
      assign seg_vin = in_valid;
    end else begin : g_skew
      logic [SEG_W-1:0] a_sk [j];
      logic [SEG_W-1:0] b_sk [j];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < j; i++) begin
            a_sk[i] <= '0;
            b_sk[i] <= '0;
          end
        end else if (adv) begin
          a_sk[0] <= a[LO +: SEG_W];
          b_sk[0] <= b_eff[LO +: SEG_W];
          for (int i = 1; i < j; i++) begin
            a_sk[i] <= a_sk[i-1];
            b_sk[i] <= b_sk[i-1];
          end
        end
      end

      assign op_a    = a_sk[j-1];
      assign op_b    = b_sk[j-1];
      assign seg_cin = stage_carry[j-1];
      assign seg_vin = stage_valid[j-1];
    end

    adder_seg_stage #(.SEG_W(SEG_W)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (adv),
      .valid_in  (seg_vin),
      .a_seg     (op_a),
      .b_seg     (op_b),
      .cin       (seg_cin),
      .sum_seg   (seg_sum),
      .cout      (stage_carry[j]),
      .zero      (seg_zero),
      .valid_out (stage_valid[j]),
      .c_msb     (seg_c_msb)
    );

    if (j == STAGES - 1) begin : g_msb
      assign top_c_msb = seg_c_msb;
    end else begin : g_no_msb
      logic unused_c_msb;
      assign unused_c_msb = seg_c_msb;
    end

    if (DELAY == 0) begin : g_direct
      assign s_aligned[LO +: SEG_W] = seg_sum;
      assign zero_aligned[j]        = seg_zero;
    end else begin : g_align
      // Early segments wait here until the top segment catches up.
      logic [SEG_W:0] r_sk [DELAY];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DELAY; i++) r_sk[i] <= '0;
        end else if (adv) begin
          r_sk[0] <= {seg_zero, seg_sum};
          for (int i = 1; i < DELAY; i++) r_sk[i] <= r_sk[i-1];
        end
      end

      assign s_aligned[LO +: SEG_W] = r_sk[DELAY-1][SEG_W-1:0];
      assign zero_aligned[j]        = r_sk[DELAY-1][SEG_W];
    end
  end

  assign sign_out = mode_q[STAGES-1][1];
  assign sub_out  = mode_q[STAGES-1][0];

  always_comb begin
    flags         = '0;
    flags[FLAG_C] = stage_carry[STAGES-1];
    flags[FLAG_Z] = &zero_aligned;
    flags[FLAG_N] = sign_out ? s_aligned[WIDTH-1]
                             : (sub_out & !stage_carry[STAGES-1]);
    flags[FLAG_V] = sign_out ? (stage_carry[STAGES-1] ^ top_c_msb)
                             : (sub_out ? !stage_carry[STAGES-1] : stage_carry[STAGES-1]);
  end

  assign out_valid = stage_valid[STAGES-1];
  assign s         = s_aligned;
  assign cout      = flags[FLAG_C];
  assign z         = flags[FLAG_Z];
  assign v         = flags[FLAG_V];
  assign n         = flags[FLAG_N];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three instances (SEG_W 8, 32, 4) fed
// with directed vectors; a monitor pops expected results as outputs transfer.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [31:0] a, b;
  logic        cin, sub, sign;
  logic [31:0] s_o [3];
  logic [2:0]  cout_o, z_o, v_o, n_o;

  typedef struct {
    int          inst;
    logic [31:0] s;
    logic [3:0]  fl;
    int          acc;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stg [3] = '{4, 1, 8};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.WIDTH(32), .SEG_W(8)) dut_main (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .sign(sign),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .s(s_o[0]),
    .cout(cout_o[0]), .z(z_o[0]), .v(v_o[0]), .n(n_o[0]));

  pipelined_adder #(.WIDTH(32), .SEG_W(32)) dut_one (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .sign(sign),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .s(s_o[1]),
    .cout(cout_o[1]), .z(z_o[1]), .v(v_o[1]), .n(n_o[1]));

  pipelined_adder #(.WIDTH(32), .SEG_W(4)) dut_eight (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .sign(sign),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .s(s_o[2]),
    .cout(cout_o[2]), .z(z_o[2]), .v(v_o[2]), .n(n_o[2]));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Flags expectation order is {cout, z, v, n}.
  task automatic applyStimulus(input int inst, input logic [31:0] aa, input logic [31:0] bb,
                               input logic ci, input logic su, input logic sg,
                               input logic [31:0] es, input logic [3:0] ef, input bit chk);
    exp_t e;
    bit   done = 0;
    a = aa; b = bb; cin = ci; sub = su; sign = sg;
    in_valid[inst] = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready[inst]) begin
        e.inst = inst; e.s = es; e.fl = ef; e.acc = cyc + 1; e.chk = chk;
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid[inst] = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL accept_timeout dut%0d: got in_ready=0 for 50 cycles, expected an accept", inst);
    end
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && out_valid[i] && out_ready[i]) begin
        if (exp_q.size() == 0 || exp_q[0].inst != i) begin
          n_cmp++; n_fail++;
          $display("[TB] FAIL unexpected_result dut%0d: got s=0x%0h, expected no result", i, s_o[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput($sformatf("result_dut%0d", i),
                      {28'd0, s_o[i], cout_o[i], z_o[i], v_o[i], n_o[i]}, {28'd0, e.s, e.fl});
          if (e.chk)
            checkOutput($sformatf("latency_dut%0d", i), 64'(cyc - e.acc + 1), 64'(stg[i]));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [35:0] held;
    reset = 1'b1; in_valid = '0; out_ready = 3'b111;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sign = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset_state_dut%0d", i),
                  {27'd0, out_valid[i], s_o[i], cout_o[i], z_o[i], v_o[i], n_o[i]}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] directed flag vectors, back to back");
    applyStimulus(0, 32'h7FFFFFFF, 32'h1, 0, 0, 1, 32'h80000000, 4'b0011, 1);
    applyStimulus(0, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h00000000, 4'b1110, 1);
    applyStimulus(0, 32'hFFFFFFFF, 32'h1, 0, 0, 1, 32'h00000000, 4'b1100, 1);
    applyStimulus(0, 32'h5,        32'h7, 0, 1, 0, 32'hFFFFFFFE, 4'b0011, 1);
    applyStimulus(0, 32'h5,        32'h7, 0, 1, 1, 32'hFFFFFFFE, 4'b0001, 1);
    applyStimulus(0, 32'h5,        32'h7, 1, 1, 0, 32'hFFFFFFFD, 4'b0011, 1);
    waitDrain();

    $display("[TB] six-beat stream with a three-cycle output stall");
    fork
      begin
        applyStimulus(0, 32'h00000001, 32'h00000002, 0, 0, 0, 32'h00000003, 4'b0000, 0);
        applyStimulus(0, 32'h000000FF, 32'h00000001, 0, 0, 0, 32'h00000100, 4'b0000, 0);
        applyStimulus(0, 32'h0000FFFF, 32'h00000001, 0, 0, 0, 32'h00010000, 4'b0000, 0);
        applyStimulus(0, 32'h80000000, 32'h80000000, 0, 0, 1, 32'h00000000, 4'b1110, 0);
        applyStimulus(0, 32'h12345678, 32'h11111111, 0, 0, 0, 32'h23456789, 4'b0000, 0);
        applyStimulus(0, 32'h00000000, 32'h00000000, 0, 1, 0, 32'h00000000, 4'b1100, 0);
      end
      begin
        bit seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(posedge clk);
          #1 seen = out_valid[0];
        end
        checkOutput("first_result_seen", 64'(seen), 64'd1);
        out_ready[0] = 1'b0;
        held = {s_o[0], cout_o[0], z_o[0], v_o[0], n_o[0]};
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 64'(in_ready[0]), 64'd0);
          checkOutput("stall_hold", {28'd0, s_o[0], cout_o[0], z_o[0], v_o[0], n_o[0]}, {28'd0, held});
          @(posedge clk);
          #1;
        end
        out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          checkOutput("stream_rate", 64'(out_valid[0]), 64'd1);
        end
      end
    join
    waitDrain();

    $display("[TB] reset with three beats in flight");
    applyStimulus(0, 32'h1, 32'h1, 0, 0, 0, 32'h2, 4'b0000, 0);
    applyStimulus(0, 32'h2, 32'h2, 0, 0, 0, 32'h4, 4'b0000, 0);
    applyStimulus(0, 32'h3, 32'h3, 0, 0, 0, 32'h6, 4'b0000, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("post_reset_valid", 64'(out_valid[0]), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(0, 32'h7FFFFFFF, 32'h1, 0, 0, 1, 32'h80000000, 4'b0011, 1);
    waitDrain();

    $display("[TB] single-stage and eight-stage instances");
    applyStimulus(1, 32'h00FFFFFF, 32'h1, 0, 0, 0, 32'h01000000, 4'b0000, 1);
    waitDrain();
    applyStimulus(2, 32'h00FFFFFF, 32'h1, 0, 0, 0, 32'h01000000, 4'b0000, 1);
    waitDrain();
    applyStimulus(2, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h00000000, 4'b1110, 1);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
